// File: rtl/count7_arb.sv
// count7_arb: round-robin arbiter that shares one modulo-HOLD counter.
// A granted requester owns CNT for 0..HOLD-1, then the counter is re-arbitrated.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   req   - per-requester level request, held for the duration of a grant
//   gnt   - registered one-hot grant, zero when idle
//   CNT   - registered shared count, 0..HOLD-1
//   busy  - high while a grant is active (|gnt)
//   done  - single-cycle pulse when CNT == HOLD-1 under an active grant
module count7_arb #(
    parameter int NREQ = 3,
    parameter int HOLD = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      CNT,
    output logic            busy,
    output logic            done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] LAST = 3'(HOLD - 1);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   pick;
    logic            found;
    logic [NREQ-1:0] gnt_nxt;
    logic [2:0]      cnt_nxt;
    logic            terminal;
    logic            held;
    logic            rearb;

    // Round-robin search: start just above the last winner and wrap,
    // so the previous holder is considered last.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[PW'((int'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    assign terminal = (state == RUN) && (CNT == LAST);
    assign held     = |(req & gnt);

    // Terminal count wins over a simultaneous release so done still pulses.
    assign rearb = terminal || !held;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        cnt_nxt   = CNT;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                gnt_nxt = '0;
                cnt_nxt = '0;
                if (found) begin
                    state_nxt     = RUN;
                    gnt_nxt[pick] = 1'b1;
                    ptr_nxt       = pick;
                end
            end
            RUN: begin
                if (rearb) begin
                    gnt_nxt = '0;
                    cnt_nxt = '0;
                    if (found) begin
                        gnt_nxt[pick] = 1'b1;
                        ptr_nxt       = pick;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = CNT + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= PTR_RST;
            gnt   <= '0;
            CNT   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
            CNT   <= cnt_nxt;
        end
    end

    assign busy = |gnt;
    assign done = terminal;

endmodule

// File: tb/tb_count7_arb.sv
// tb_count7_arb: scoreboard bench for count7_arb.
// Per-cycle expectations come from a behavioural model of the arbiter.
module tb_count7_arb;

    localparam int NREQ = 3;
    localparam int HOLD = 7;
    localparam int OW   = NREQ + 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [2:0]      CNT;
    logic            busy;
    logic            done;

    count7_arb #(.NREQ(NREQ), .HOLD(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .CNT  (CNT),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] sb[$];

    // Model: holder index (-1 when idle), count, last-winner pointer.
    int m_hold = -1;
    int m_cnt  = 0;
    int m_ptr  = NREQ - 1;

    function automatic logic [OW-1:0] model_out();
        logic [NREQ-1:0] g;
        logic            act;
        logic            dn;
        g   = '0;
        act = (m_hold >= 0);
        dn  = act && (m_cnt == HOLD - 1);
        if (act) g[m_hold] = 1'b1;
        return {g, 3'(m_cnt), act, dn};
    endfunction

    task automatic model_reset();
        m_hold = -1;
        m_cnt  = 0;
        m_ptr  = NREQ - 1;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r);
        bit arb;
        int c;
        arb = (m_hold < 0) || (m_cnt == HOLD - 1) || !r[m_hold];
        if (!arb) begin
            m_cnt = m_cnt + 1;
        end else begin
            m_hold = -1;
            m_cnt  = 0;
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (m_hold < 0 && r[c]) begin
                    m_hold = c;
                    m_ptr  = c;
                end
            end
        end
    endtask

    // Drive req at negedge, push the expected post-edge outputs,
    // then advance to just after the rising edge.
    task automatic drive(input logic [NREQ-1:0] r);
        @(negedge clk);
        req = r;
        model_edge(r);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] got;
        rst = 1'b0;
        req = '0;
        #3;
        got = {gnt, CNT, busy, done};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", got, {OW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_first_grant();
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        int ndone;
        ndone = 0;
        for (int i = 0; i < 2 * HOLD; i++) begin
            drive(3'b001);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL first_grant[%0d] got=%b want=%b", i, got, exp);
            end
            checks++;
            if (gnt !== 3'b001 || CNT !== 3'(i % HOLD)) begin
                errors++;
                $display("FAIL first_seq[%0d] gnt=%b cnt=%0d want gnt=001 cnt=%0d",
                         i, gnt, CNT, i % HOLD);
            end
            if (done) ndone++;
        end
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL first_done_count got=%0d want=2", ndone);
        end
    endtask

    task automatic test_round_robin();
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        logic [NREQ-1:0] order[4];
        int ng;
        ng = 0;
        for (int i = 0; i < 4 * HOLD; i++) begin
            drive(3'b011);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL round_robin[%0d] got=%b want=%b", i, got, exp);
            end
            if (CNT == 3'd0 && ng < 4) begin
                order[ng] = gnt;
                ng++;
            end
        end
        checks++;
        if (ng != 4 || order[0] !== 3'b010 || order[1] !== 3'b001 ||
            order[2] !== 3'b010 || order[3] !== 3'b001) begin
            errors++;
            $display("FAIL rr_order got=%b %b %b %b want=010 001 010 001",
                     order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_all_requesters();
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        for (int i = 0; i < 3 * HOLD; i++) begin
            drive(3'b111);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL all_req[%0d] got=%b want=%b", i, got, exp);
            end
        end
        checks++;
        if (gnt !== 3'b001 || CNT !== 3'(HOLD - 1)) begin
            errors++;
            $display("FAIL all_req_wrap gnt=%b cnt=%0d want gnt=001 cnt=%0d",
                     gnt, CNT, HOLD - 1);
        end
    endtask

    task automatic test_early_release();
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        int sawdone;
        sawdone = 0;
        for (int i = 0; i < 20; i++) begin
            drive(3'b010);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL early_hold[%0d] got=%b want=%b", i, got, exp);
            end
            if (done) sawdone++;
            if (m_hold == 1 && m_cnt == 3) break;
        end
        checks++;
        if (gnt !== 3'b010 || CNT !== 3'd3) begin
            errors++;
            $display("FAIL early_setup gnt=%b cnt=%0d want gnt=010 cnt=3", gnt, CNT);
        end
        drive(3'b100);
        exp = sb.pop_front();
        got = {gnt, CNT, busy, done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL early_handover got=%b want=%b", got, exp);
        end
        checks++;
        if (gnt !== 3'b100 || CNT !== 3'd0 || sawdone != 0) begin
            errors++;
            $display("FAIL early_next gnt=%b cnt=%0d dones=%0d want gnt=100 cnt=0 dones=0",
                     gnt, CNT, sawdone);
        end
        drive(3'b100);
        void'(sb.pop_front());
        drive(3'b000);
        exp = sb.pop_front();
        got = {gnt, CNT, busy, done};
        checks++;
        if (got !== exp || gnt !== 3'b000) begin
            errors++;
            $display("FAIL early_to_idle got=%b want=%b", got, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        for (int i = 0; i < 20; i++) begin
            drive(3'b001);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL areset_pre[%0d] got=%b want=%b", i, got, exp);
            end
            if (m_hold == 0 && m_cnt == 4) break;
        end
        #2;
        rst = 1'b0;
        #1;
        got = {gnt, CNT, busy, done};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL areset_clear got=%b want=%b", got, {OW{1'b0}});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(3'b110);
        exp = sb.pop_front();
        got = {gnt, CNT, busy, done};
        checks++;
        if (got !== exp || gnt !== 3'b010) begin
            errors++;
            $display("FAIL areset_ptr got=%b want=%b gnt want=010", got, exp);
        end
    endtask

    task automatic test_idle_return();
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        for (int i = 0; i < 20; i++) begin
            drive(3'b100);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL idle_grant[%0d] got=%b want=%b", i, got, exp);
            end
            if (m_hold == 2 && m_cnt == HOLD - 1) break;
        end
        checks++;
        if (gnt !== 3'b100 || done !== 1'b1) begin
            errors++;
            $display("FAIL idle_done gnt=%b done=%b want gnt=100 done=1", gnt, done);
        end
        for (int i = 0; i < 4; i++) begin
            drive(3'b000);
            exp = sb.pop_front();
            got = {gnt, CNT, busy, done};
            checks++;
            if (got !== exp || got !== '0) begin
                errors++;
                $display("FAIL idle_hold[%0d] got=%b want=%b", i, got, exp);
            end
        end
        drive(3'b001);
        exp = sb.pop_front();
        got = {gnt, CNT, busy, done};
        checks++;
        if (got !== exp || gnt !== 3'b001) begin
            errors++;
            $display("FAIL idle_regrant got=%b want=%b", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_round_robin();
        test_all_requesters();
        test_early_release();
        test_async_reset();
        test_idle_return();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count7_arb.md
# count7_arb

Round-robin arbiter that shares one modulo-7 counting resource among several requesters. A requester raising `req` is granted exclusive use of the counter, which then runs 0..HOLD-1 on its behalf. A one-cycle `done` marks the terminal count, after which the counter is re-arbitrated. The block sits above the count-to-7 counter in the design and supplies the sequencing and sharing that the bare counter lacks. The counter is embedded, so `CNT` is driven from inside this block.

## Interface
- NREQ, 3, number of requesters (2..8)
- HOLD, 7, counts per grant; CNT runs 0..HOLD-1 (2..8)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester request; level, held for the duration of the grant
- gnt  output  NREQ  one-hot grant, registered; all-zero when idle
- CNT  output  3  shared count value, registered
- busy  output  1  high while any grant is active (equals |gnt)
- done  output  1  high for the single cycle in which CNT == HOLD-1 under an active grant

## Operation
- States: IDLE and RUN.
- IDLE:
  - gnt=0, CNT=0, busy=0, done=0.
  - On a clock edge with any req bit high, go to RUN.
  - The granted bit is the first set req found searching upward from ptr+1, with wrap-around.
  - ptr is set to the granted index.
  - CNT is loaded with 0.
- RUN, granted requester still requesting, CNT < HOLD-1: CNT increments by 1 per edge and gnt is held.
- RUN, CNT == HOLD-1 (terminal):
  - done=1 in this cycle.
  - Arbitration occurs on the next edge using the same round-robin rule.
  - The current holder is lowest priority for that arbitration.
  - If any req is high, the new gnt and CNT=0 load on that edge, with no idle gap (back-to-back).
  - Otherwise go to IDLE.
- RUN, granted requester's req low (early release):
  - On the next edge the grant ends and done is not pulsed.
  - Arbitration runs on that same edge, exactly as at terminal count.
- Requests from non-granted requesters never disturb an active grant.
- A req that drops before it is granted is simply not selected.
- Simultaneous terminal count and release by the holder: treat as terminal. done=1 in the terminal cycle, then arbitrate.
- Pointer reset value is ptr = NREQ-1, so req[0] wins the first arbitration.
- CNT wraps only through re-arbitration. It never exceeds HOLD-1.
- Upper CNT bits beyond clog2(HOLD) are 0.

## Timing
- Reset values: gnt=0, CNT=0, busy=0, done=0, state=IDLE, ptr=NREQ-1.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- Grant latency is 1 edge: a req sampled high at an edge in IDLE gives gnt at that edge's output.
- A full grant lasts exactly HOLD cycles, CNT = 0,1,..,HOLD-1.
- done coincides with CNT == HOLD-1.
- Back-to-back handover: the cycle after done shows the new gnt with CNT=0.
- Early release: the grant ends 1 edge after req falls. CNT at that edge is either the next grant's 0 or IDLE's 0.
- All outputs are registered or decoded only from registers; there are no combinational req→gnt paths.

## Test plan
- **Reset and first grant.** rst low then high, req=001 held. Required response:
  - gnt=001 on the 1st edge.
  - CNT steps 0..6.
  - done=1 only at CNT=6.
  - After that, a new grant to 001 with CNT=0 (sole requester regrants back-to-back).
- **Round-robin handover.** req=011 held. Required response:
  - Grant order 001, 010, 001, 010…, each lasting 7 cycles.
  - No idle cycle between grants.
  - done pulses once per grant.
- **All requesters.** req=111 held. Grants rotate 001→010→100→001, and ptr wraps correctly.
- **Early release.** Grant to 010, req[1] dropped at CNT=3. Required response:
  - Next edge: gnt moves to the next pending requester, or to 0 if none.
  - CNT=0.
  - done never pulses for that grant.
- **Async reset mid-grant.** Assert rst low at CNT=4 between clock edges. Required response:
  - gnt=0, CNT=0, busy=0, done=0 immediately.
  - After release, req=110 is granted to 010 first (ptr reset).
- **Idle return.** Single grant to 100, req dropped after done. Required response: IDLE with gnt=0, busy=0, CNT=0 held until a new req.
